// File: rtl/aclk_keybuf.sv
// Key-entry buffer for the alarm-clock datapath: newest decimal key in digit 0,
// with backspace, clear, valid-digit count and overflow/reject pulses.
module aclk_keybuf #(
  parameter int DIGITS  = 4,
  parameter int KEY_W   = 4,
  parameter int MAX_KEY = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      shift,
  input  logic [KEY_W-1:0]          key,
  input  logic                      bksp,
  input  logic                      clear,
  output logic [DIGITS*KEY_W-1:0]   key_buffer,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      reject
);

  localparam int CW = $clog2(DIGITS+1);

  logic [KEY_W-1:0] digit_q [DIGITS];
  logic [KEY_W-1:0] digit_d [DIGITS];
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_d, reject_d;
  logic             key_ok;
  logic             full_w, empty_w;

  // Unsigned compare; key is zero-extended so MAX_KEY >= 2**KEY_W accepts all codes.
  assign key_ok  = (32'(key) <= 32'(MAX_KEY));
  assign full_w  = (count_q == CW'(DIGITS));
  assign empty_w = (count_q == '0);

  always_comb begin
    for (int i = 0; i < DIGITS; i++) digit_d[i] = digit_q[i];
    count_d    = count_q;
    overflow_d = 1'b0;
    reject_d   = 1'b0;

    if (clear) begin
      for (int i = 0; i < DIGITS; i++) digit_d[i] = '0;
      count_d = '0;
    end else if (bksp) begin
      if (!empty_w) begin
        for (int i = 0; i < DIGITS-1; i++) digit_d[i] = digit_q[i+1];
        digit_d[DIGITS-1] = '0;
        count_d = count_q - 1'b1;
      end
    end else if (shift) begin
      if (key_ok) begin
        for (int i = DIGITS-1; i > 0; i--) digit_d[i] = digit_q[i-1];
        digit_d[0] = key;
        if (full_w) overflow_d = 1'b1;
        else        count_d    = count_q + 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      reject   <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= digit_d[i];
      count_q  <= count_d;
      overflow <= overflow_d;
      reject   <= reject_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_pack
    assign key_buffer[g*KEY_W +: KEY_W] = digit_q[g];
  end

  assign count = count_q;
  assign full  = full_w;
  assign empty = empty_w;

endmodule

// File: doc/aclk_keybuf.md
# aclk_keybuf

Parametrised key-entry buffer for the alarm-clock datapath, sitting between the keypad FSM and the time/alarm registers. It holds the last DIGITS decimal keys pressed, newest in the least-significant digit, and supports backspace, clear, and an entered-digit count. It rejects non-decimal key codes and flags the loss of the oldest digit on overflow. With DIGITS=4 its output maps directly onto LS_MIN/MS_MIN/LS_HR/MS_HR.

## Interface
- DIGITS, 4, number of digit slots (≥2)
- KEY_W, 4, bits per digit/key code (≥4)
- MAX_KEY, 9, largest accepted key code; codes above it are rejected
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- shift  input  1  push `key` into digit 0 (one-cycle pulse from the FSM)
- key  input  KEY_W  key code sampled when shift=1
- bksp  input  1  delete the newest digit
- clear  input  1  empty the buffer
- key_buffer  output  DIGITS*KEY_W  digit i at bits [i*KEY_W +: KEY_W], digit 0 = newest/LS
- count  output  $clog2(DIGITS+1)  number of valid digits entered, 0..DIGITS
- full  output  1  count == DIGITS (combinational from count)
- empty  output  1  count == 0 (combinational from count)
- overflow  output  1  registered one-cycle pulse: an accepted shift occurred while full
- reject  output  1  registered one-cycle pulse: a shift with key > MAX_KEY was ignored

## Operation
- Reset (asynchronous, immediate): all digits 0, count 0, overflow 0, reject 0.
- Per-edge priority: clear > bksp > shift. Only the highest-priority asserted command acts; the others are dropped without any flag.
- clear: all digits ← 0, count ← 0.
- bksp: digit i ← digit i+1 for i < DIGITS-1, top digit ← 0, count ← count-1. When count=0, bksp leaves the digits unchanged and count stays 0.
- shift with key ≤ MAX_KEY (accepted):
  - digit i+1 ← digit i, digit 0 ← key.
  - count ← min(count+1, DIGITS).
  - If count was DIGITS before the edge, the old top digit is discarded and overflow pulses.
- shift with key > MAX_KEY: digits and count are unchanged, and reject pulses.
- overflow and reject are cleared every cycle unless re-asserted. They are 0 on cycles where clear or bksp wins.
- No command asserted: all state holds.
- Invariant: digits at index ≥ count are always 0.
- Comparison `key > MAX_KEY` is unsigned at KEY_W bits.

## Timing
- All state updates on the rising clk edge where the command is sampled. key_buffer and count show the new value in the following cycle, giving 1-cycle latency.
- overflow and reject assert in the cycle after the offending shift and stay high for exactly one cycle.
- Back-to-back shifts on consecutive cycles are each accepted, giving one digit per cycle.
- A reset asserted mid-sequence clears the buffer immediately. The first edge after reset deasserts is a normal edge and may accept a shift.
- full and empty are combinational from registered count and are glitch-free relative to clk.

## Test plan
- Reset, then shift keys 1,2,3,4 on consecutive cycles -> key_buffer = 0x1234 (MS→LS), count = 4, full = 1, overflow never asserted.
- From 0x1234 full, shift key 5 -> key_buffer = 0x2345, count = 4, overflow = 1 for one cycle, then 0.
- From 0x0012 (count 2), shift key 0xA -> buffer unchanged 0x0012, count 2, reject = 1 for one cycle. Then shift key 9 -> 0x0129, count 3, reject = 0.
- From 0x0129 (count 3), bksp ×4 -> 0x0012 → 0x0001 → 0x0000 (count 0) → 0x0000 with count held at 0 and empty = 1.
- From 0x0012, assert clear+bksp+shift(7) together -> 0x0000, count 0, no pulse. Then bksp+shift(7) together -> bksp wins, state still 0x0000, count 0.
- Mid-sequence reset: after shifting 3,4, pulse reset between edges -> outputs go to 0 immediately without a clock edge. Then shift 8 -> 0x0008, count 1. Repeat the 4-digit sequence with DIGITS=6, KEY_W=4 and check 24-bit packing.
